// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster, channel-interleaved sample stream.
// Define MAXPOOL_FP32_CMP_EN to compare samples as IEEE-754 binary32 instead of signed integers.
module maxpool2x2_stream #(
    parameter int unsigned IMG_Width  = 5,
    parameter int unsigned IMG_Height = 5,
    parameter int unsigned Channel    = 12,
    parameter int unsigned Datawidth  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] data_in,
    output logic                 valid_out,
    output logic [Datawidth-1:0] data_out
);

    localparam int unsigned CH_W     = (Channel > 1) ? $clog2(Channel) : 1;
    localparam int unsigned COL_W    = $clog2(IMG_Width + 1);
    localparam int unsigned ROW_W    = $clog2(IMG_Height + 1);
    localparam int unsigned PAIRS    = IMG_Width / 2;
    localparam int unsigned LB_DEPTH = PAIRS * Channel;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int unsigned USED_COLS = 2 * PAIRS;
    localparam int unsigned USED_ROWS = 2 * (IMG_Height / 2);

    // Returns b only when it is strictly greater, so ties keep the earlier operand a.
    function automatic logic [Datawidth-1:0] pool_max(input logic [Datawidth-1:0] a,
                                                      input logic [Datawidth-1:0] b);
        logic b_wins;
`ifdef MAXPOOL_FP32_CMP_EN
        if (a[Datawidth-1] != b[Datawidth-1])
            b_wins = a[Datawidth-1] && ((a[Datawidth-2:0] | b[Datawidth-2:0]) != '0);
        else if (!a[Datawidth-1])
            b_wins = b[Datawidth-2:0] > a[Datawidth-2:0];
        else
            b_wins = b[Datawidth-2:0] < a[Datawidth-2:0];
`else
        b_wins = $signed(b) > $signed(a);
`endif
        return b_wins ? b : a;
    endfunction

    logic [CH_W-1:0]      ch_q;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [Datawidth-1:0] hold_q [Channel];
    logic [Datawidth-1:0] lb_q   [LB_DEPTH];

    logic                 last_ch_c;
    logic                 last_col_c;
    logic                 last_row_c;
    logic                 in_window_c;
    logic                 complete_c;
    logic [LB_AW-1:0]     lb_idx_c;
    logic [Datawidth-1:0] pair_c;
    logic [Datawidth-1:0] result_c;

    // Position decode and the two-stage max for the current sample.
    always_comb begin
        last_ch_c   = (ch_q == CH_W'(Channel - 1));
        last_col_c  = (col_q == COL_W'(IMG_Width - 1));
        last_row_c  = (row_q == ROW_W'(IMG_Height - 1));
        in_window_c = (32'(col_q) < 32'(USED_COLS)) && (32'(row_q) < 32'(USED_ROWS));
        complete_c  = valid_in && in_window_c && col_q[0] && row_q[0];
        lb_idx_c    = LB_AW'((32'(col_q) >> 1) * 32'(Channel) + 32'(ch_q));
        pair_c      = pool_max(hold_q[ch_q], data_in);
        result_c    = pool_max(lb_q[lb_idx_c], pair_c);
    end

    // Raster position counters; a frame wraps straight into the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q  <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (valid_in) begin
            if (last_ch_c) begin
                ch_q <= '0;
                if (last_col_c) begin
                    col_q <= '0;
                    row_q <= last_row_c ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end else begin
                ch_q <= ch_q + CH_W'(1);
            end
        end
    end

    // Pair and line storage; a trailing odd column or row never touches it.
    always_ff @(posedge clk) begin
        if (valid_in && in_window_c) begin
            if (!col_q[0])
                hold_q[ch_q] <= data_in;
            else if (!row_q[0])
                lb_q[lb_idx_c] <= pair_c;
        end
    end

    // Registered result; data_out keeps its last value between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= complete_c;
            if (complete_c)
                data_out <= result_c;
        end
    end

endmodule
